// File: rtl/fractal_sync_rf_initiator.sv
`default_nettype none
// ============================================================================
// Module   : fractal_sync_rf_initiator
// Purpose  : Requester-side front end for one port of a fractal-sync remote
//            register file. Buffers (level, id) sync requests in a small FIFO.
//            Each request is issued to the RF port as a one-cycle check. The RF
//            reply is classified and returned as a registered response.
// Ports    : clk_i, rst_ni (async, active-low)
//            req_*  : request handshake in (valid/ready, level, id)
//            rf_*   : RF port (level/id/check out; present/sig_err/bypass/ignore in)
//            rsp_*  : response handshake out (valid/ready, type, level, id)
//            stat_* : optional statistics (FRACTAL_SYNC_RF_INIT_STATS_EN)
// Response : 00 STORED, 01 MATCH, 10 IGNORED, 11 ERROR
// Revision : 1.0 - initial release
// ============================================================================
module fractal_sync_rf_initiator #(
    parameter int LEVEL_WIDTH = 1,
    parameter int ID_WIDTH    = 1,
    parameter int FIFO_DEPTH  = 2,
    parameter int STAT_WIDTH  = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [LEVEL_WIDTH-1:0] req_level_i,
    input  logic [ID_WIDTH-1:0]    req_id_i,
    output logic [LEVEL_WIDTH-1:0] rf_level_o,
    output logic [ID_WIDTH-1:0]    rf_id_o,
    output logic                   rf_check_o,
    input  logic                   rf_present_i,
    input  logic                   rf_sig_err_i,
    input  logic                   rf_bypass_i,
    input  logic                   rf_ignore_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [1:0]             rsp_type_o,
    output logic [LEVEL_WIDTH-1:0] rsp_level_o,
    output logic [ID_WIDTH-1:0]    rsp_id_o
`ifdef FRACTAL_SYNC_RF_INIT_STATS_EN
    ,
    input  logic                   stat_clr_i,
    output logic [STAT_WIDTH-1:0]  stat_match_o,
    output logic [STAT_WIDTH-1:0]  stat_stored_o,
    output logic [STAT_WIDTH-1:0]  stat_err_o
`endif
);

    localparam int               c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int               c_CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(FIFO_DEPTH);

    localparam logic [1:0] c_RSP_STORED  = 2'b00;
    localparam logic [1:0] c_RSP_MATCH   = 2'b01;
    localparam logic [1:0] c_RSP_IGNORED = 2'b10;
    localparam logic [1:0] c_RSP_ERROR   = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Request FIFO
    // ------------------------------------------------------------------
    logic [LEVEL_WIDTH-1:0] r_lvl_mem [FIFO_DEPTH];
    logic [ID_WIDTH-1:0]    r_id_mem  [FIFO_DEPTH];
    logic [c_PTR_W-1:0]     r_wr_ptr;
    logic [c_PTR_W-1:0]     r_rd_ptr;
    logic [c_CNT_W-1:0]     r_count;
    logic [c_CNT_W-1:0]     w_count_next;

    state_t                 r_state;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_push;
    logic                   w_pop;
    logic [LEVEL_WIDTH-1:0] w_head_level;
    logic [ID_WIDTH-1:0]    w_head_id;
    logic [1:0]             w_rsp_type;

    assign w_full  = (r_count == c_FULL);
    assign w_empty = (r_count == '0);
    // Full blocks the push even when a pop frees a slot in the same cycle.
    assign w_push  = req_valid_i & ~w_full;
    assign w_pop   = (r_state == S_ISSUE);

    assign w_head_level = w_empty ? '0 : r_lvl_mem[r_rd_ptr];
    assign w_head_id    = w_empty ? '0 : r_id_mem[r_rd_ptr];

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + 1'b1;
            2'b01:   w_count_next = r_count - 1'b1;
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_lvl_mem[i] <= '0;
                r_id_mem[i]  <= '0;
            end
        end else begin
            if (w_push) begin
                r_lvl_mem[r_wr_ptr] <= req_level_i;
                r_id_mem[r_wr_ptr]  <= req_id_i;
                r_wr_ptr            <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_count_next;
        end
    end

    // ------------------------------------------------------------------
    // Reply classification; sig_err outranks a hit, a hit outranks ignore.
    // ------------------------------------------------------------------
    always_comb begin
        w_rsp_type = c_RSP_STORED;
        if (rf_sig_err_i) begin
            w_rsp_type = c_RSP_ERROR;
        end else if (rf_bypass_i | rf_present_i) begin
            w_rsp_type = c_RSP_MATCH;
        end else if (rf_ignore_i) begin
            w_rsp_type = c_RSP_IGNORED;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM with registered check strobe and response
    // ------------------------------------------------------------------
    logic                   r_rf_check;
    logic                   r_rsp_valid;
    logic [1:0]             r_rsp_type;
    logic [LEVEL_WIDTH-1:0] r_rsp_level;
    logic [ID_WIDTH-1:0]    r_rsp_id;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= S_IDLE;
            r_rf_check  <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_type  <= '0;
            r_rsp_level <= '0;
            r_rsp_id    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        r_state    <= S_ISSUE;
                        r_rf_check <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    r_rf_check  <= 1'b0;
                    r_rsp_valid <= 1'b1;
                    r_rsp_type  <= w_rsp_type;
                    r_rsp_level <= w_head_level;
                    r_rsp_id    <= w_head_id;
                    r_state     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready_i) begin
                        r_rsp_valid <= 1'b0;
                        // A request pushed during this cycle counts as pending.
                        if (w_count_next != '0) begin
                            r_state    <= S_ISSUE;
                            r_rf_check <= 1'b1;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_rf_check  <= 1'b0;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready_o = ~w_full;
    assign rf_level_o  = w_head_level;
    assign rf_id_o     = w_head_id;
    assign rf_check_o  = r_rf_check;
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_type_o  = r_rsp_type;
    assign rsp_level_o = r_rsp_level;
    assign rsp_id_o    = r_rsp_id;

`ifdef FRACTAL_SYNC_RF_INIT_STATS_EN
    // ------------------------------------------------------------------
    // Saturating statistics; clear wins over a same-cycle increment.
    // ------------------------------------------------------------------
    logic [STAT_WIDTH-1:0] r_stat_match;
    logic [STAT_WIDTH-1:0] r_stat_stored;
    logic [STAT_WIDTH-1:0] r_stat_err;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_stat_match  <= '0;
            r_stat_stored <= '0;
            r_stat_err    <= '0;
        end else if (stat_clr_i) begin
            r_stat_match  <= '0;
            r_stat_stored <= '0;
            r_stat_err    <= '0;
        end else if (w_pop) begin
            if ((w_rsp_type == c_RSP_MATCH) && !(&r_stat_match)) begin
                r_stat_match <= r_stat_match + 1'b1;
            end
            if ((w_rsp_type == c_RSP_STORED) && !(&r_stat_stored)) begin
                r_stat_stored <= r_stat_stored + 1'b1;
            end
            if ((w_rsp_type == c_RSP_ERROR) && !(&r_stat_err)) begin
                r_stat_err <= r_stat_err + 1'b1;
            end
        end
    end

    assign stat_match_o  = r_stat_match;
    assign stat_stored_o = r_stat_stored;
    assign stat_err_o    = r_stat_err;
`else
    // Statistics width only matters when the counters exist.
    logic w_unused_stat_width;
    assign w_unused_stat_width = (STAT_WIDTH > 0);
`endif

endmodule
`default_nettype wire

// File: doc/fractal_sync_rf_initiator.md
Name: fractal_sync_rf_initiator

Overview:
- Requester-side front end for one port of a 1D or 2D fractal-sync remote register file.
- Accepts sync requests (level, id) from the local node or a lower tree level over a valid/ready handshake, and buffers them in a small FIFO.
- Issues each request as a one-cycle check on the RF port, classifies the RF reply, and returns a registered response (STORED / MATCH / IGNORED / ERROR) to the requester over a second valid/ready handshake.
- One instance per RF port; the parent node instantiates N_PORTS of them alongside the RF.

Parameters:
- LEVEL_WIDTH, 1, width of the level field; must equal the RF's LEVEL_WIDTH.
- ID_WIDTH, 1, width of the id field; must equal the RF's ID_WIDTH.
- FIFO_DEPTH, 2, request FIFO entries; at least 2, power of two.
- STAT_WIDTH, 16, statistics counter width; used only with the optional feature.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset: one clock; reset is asynchronous and active-low.
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request ready; equals ~fifo_full
- req_level_i  in  LEVEL_WIDTH  request level
- req_id_i  in  ID_WIDTH  request id
- rf_level_o  out  LEVEL_WIDTH  level to RF port; FIFO head, 0 when empty
- rf_id_o  out  ID_WIDTH  id to RF port; FIFO head, 0 when empty
- rf_check_o  out  1  check strobe to RF port
- rf_present_i  in  1  RF present flag
- rf_sig_err_i  in  1  RF signature-out-of-range flag
- rf_bypass_i  in  1  RF same-cycle-pair flag
- rf_ignore_i  in  1  RF handled-by-other-port flag
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response ready
- rsp_type_o  out  2  response code: 00 STORED, 01 MATCH, 10 IGNORED, 11 ERROR
- rsp_level_o  out  LEVEL_WIDTH  level of the answered request
- rsp_id_o  out  ID_WIDTH  id of the answered request

Behaviour:
- Reset values:
  - FIFO empty, so req_ready_o=1.
  - FSM in IDLE.
  - rf_check_o=0; rf_level_o and rf_id_o = 0.
  - rsp_valid_o=0; rsp_type_o, rsp_level_o, rsp_id_o = 0.
- FIFO:
  - Push on req_valid_i & req_ready_o.
  - Pop only in ISSUE.
  - When full, req_ready_o=0, so no push occurs even if a pop happens that cycle.
  - Pointers wrap modulo FIFO_DEPTH; a separate count distinguishes full from empty.
  - A pushed entry is visible at the head no earlier than the next cycle.
- FSM states:
  - IDLE: go to ISSUE if the FIFO is non-empty.
  - ISSUE:
    - rf_check_o=1 for exactly this cycle, with rf_level_o and rf_id_o driven from the FIFO head.
    - RF outputs are sampled this same cycle; the RF is combinational on present and updates its storage at the next edge.
    - Response is registered, the FIFO is popped, then go to RESP.
  - RESP:
    - rsp_valid_o=1, response fields held stable.
    - On rsp_ready_i: go to ISSUE if the FIFO is still non-empty after this cycle, else to IDLE.
- Classification, in priority order:
  - rf_sig_err_i gives ERROR.
  - Else rf_bypass_i | rf_present_i gives MATCH.
  - Else rf_ignore_i gives IGNORED.
  - Else STORED.
- Latency:
  - Request accepted at edge N → ISSUE at cycle N+1 (from IDLE) → rsp_valid_o high at cycle N+2.
  - Sustained throughput is one request per 2 cycles when rsp_ready_i is held at 1.
- rf_check_o never asserts in IDLE or RESP; exactly one check per dequeued request.
- Backpressure on rsp_ready_i stalls the FSM in RESP and accumulates requests in the FIFO. No request is dropped and no check is issued while stalled.
- rsp_level_o and rsp_id_o echo the issued entry unchanged.
- Reset mid-operation:
  - All state returns to reset values and FIFO contents are discarded.
  - A check already issued is not replayed; the RF shares the reset.

Optional Feature:
- Macro: FRACTAL_SYNC_RF_INIT_STATS_EN.
- When defined, adds these ports:
  - stat_clr_i  in  1
  - stat_match_o  out  STAT_WIDTH
  - stat_stored_o  out  STAT_WIDTH
  - stat_err_o  out  STAT_WIDTH
- Counter behaviour:
  - Each counter increments by 1 in the ISSUE cycle whose classification is MATCH, STORED or ERROR respectively.
  - Counters saturate at all-ones and reset to 0.
  - stat_clr_i zeroes all counters and takes priority over an increment in the same cycle.
  - IGNORED is not counted.
- When undefined, these ports and counters do not exist and the remaining behaviour is identical.

Test Plan:
- Reset, then a single request level=1 id=0 with RF inputs all 0 → rf_check_o=1 for exactly 1 cycle at cycle 1; rsp_valid_o=1 at cycle 2 with rsp_type_o=00, rsp_id_o=0.
- Same request with rf_present_i=1 during ISSUE → rsp_type_o=01. Then rf_sig_err_i=1 together with rf_present_i=1 → rsp_type_o=11 (priority).
- rf_ignore_i=1, rf_bypass_i=0 → rsp_type_o=10. rf_ignore_i=1, rf_bypass_i=1 → rsp_type_o=01.
- FIFO_DEPTH=2, rsp_ready_i=0, four back-to-back requests ids 0,1,2,3 → the first issues, ids 1 and 2 fill the FIFO, req_ready_o=0 while id 3 is offered. Release rsp_ready_i → responses in order 0,1,2; id 3 is accepted once space frees; exactly one rf_check_o pulse per request.
- Assert rst_ni=0 while in RESP with 2 entries queued → rsp_valid_o=0, req_ready_o=1 immediately; no further rf_check_o pulses after release.
- With FRACTAL_SYNC_RF_INIT_STATS_EN and STAT_WIDTH=2, issue 5 MATCH responses → stat_match_o saturates at 3. Then stat_clr_i=1 in the same cycle as a MATCH issue → stat_match_o=0.
